// File: rtl/clk_div_monitor.sv
// clk_div_monitor: watches a divided clock from the source clock domain and
// checks its period and high time against the expected ratio N. It raises
// error pulses when a period is wrong, and it raises a lock level after a
// run of good periods.
module clk_div_monitor #(
  parameter int N           = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_clk_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             err_period,
  output logic             err_duty,
  output logic             locked
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] N_VAL   = CNT_W'(N);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(2 * N);
  localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(N / 2);
  localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'((N + 1) / 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;

  logic [CNT_W-1:0] cyc, cyc_next;
  logic [CNT_W-1:0] hi, hi_next;
  logic [CNT_W-1:0] cyc_inc, hi_inc;
  logic [CNT_W-1:0] period_next, high_next;
  logic [RUN_W-1:0] run, run_next;
  logic             mv_next, ep_next, ed_next, lk_next;
  logic             timeout, good_len, good_duty;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // cyc doubles as the timeout timer in ARM; both counters saturate
  assign cyc_inc   = (cyc == CNT_MAX) ? cyc : cyc + CNT_ONE;
  assign hi_inc    = (s && (hi != CNT_MAX)) ? hi + CNT_ONE : hi;
  assign timeout   = (cyc >= TIMEOUT);
  assign good_len  = (cyc == N_VAL);
  assign good_duty = (hi >= HI_MIN) && (hi <= HI_MAX);

  // Synchronizer chain for the asynchronous divided clock, plus one delay flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
      s_d    <= s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-value logic; a rise always beats a coinciding timeout
  always_comb begin
    state_next  = state;
    cyc_next    = cyc;
    hi_next     = hi;
    period_next = period_cnt;
    high_next   = high_cnt;
    run_next    = run;
    mv_next     = 1'b0;
    ep_next     = 1'b0;
    ed_next     = 1'b0;
    lk_next     = locked;

    if (!enable) begin
      state_next = IDLE;
      cyc_next   = '0;
      hi_next    = '0;
      run_next   = '0;
      lk_next    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = ARM;
          cyc_next   = CNT_ONE;
          hi_next    = '0;
        end
        ARM: begin
          if (rise) begin
            state_next = MEASURE;
            cyc_next   = CNT_ONE;
            hi_next    = {{(CNT_W-1){1'b0}}, s};
          end else if (timeout) begin
            ep_next  = 1'b1;
            run_next = '0;
            lk_next  = 1'b0;
            cyc_next = CNT_ONE;
          end else begin
            cyc_next = cyc_inc;
          end
        end
        MEASURE: begin
          if (rise) begin
            mv_next     = 1'b1;
            period_next = cyc;
            high_next   = hi;
            cyc_next    = CNT_ONE;
            hi_next     = CNT_ONE;
            if (!good_len) begin
              ep_next  = 1'b1;
              run_next = '0;
              lk_next  = 1'b0;
            end else if (!good_duty) begin
              ed_next  = 1'b1;
              run_next = '0;
              lk_next  = 1'b0;
            end else begin
              run_next = (run == RUN_MAX) ? run : run + RUN_ONE;
              lk_next  = (run_next == RUN_MAX);
            end
          end else if (timeout) begin
            state_next = ARM;
            ep_next    = 1'b1;
            run_next   = '0;
            lk_next    = 1'b0;
            cyc_next   = CNT_ONE;
            hi_next    = '0;
          end else begin
            cyc_next = cyc_inc;
            hi_next  = hi_inc;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Measurement counters, run counter and registered outputs; reset drops locked immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc        <= '0;
      hi         <= '0;
      run        <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      err_period <= 1'b0;
      err_duty   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      cyc        <= cyc_next;
      hi         <= hi_next;
      run        <= run_next;
      period_cnt <= period_next;
      high_cnt   <= high_next;
      meas_valid <= mv_next;
      err_period <= ep_next;
      err_duty   <= ed_next;
      locked     <= lk_next;
    end
  end

endmodule
